// File: rtl/firc_coef_bank_if.sv
// Coefficient bank bus: host write port, sequencer swap strobe,
// multiplier read ports and status outputs of firc_coef_bank.
//
// Handshake: PushCoef is a plain write strobe with no ready/backpressure.
// Every cycle it is high, one coefficient is consumed. SwapReq is a one-cycle
// request. SwapAck and CoefErr are one-cycle responses, registered, appearing
// the cycle after the event that caused them.
interface firc_coef_bank_if #(
  parameter int AW  = 5,
  parameter int CW  = 27,
  parameter int NRD = 5
);
  logic                PushCoef;
  logic [AW-1:0]       CoefAddr;
  logic [CW-1:0]       CoefI;
  logic [CW-1:0]       CoefQ;
  logic                SwapReq;
  logic [NRD*AW-1:0]   RdAddr;
  logic [NRD*CW-1:0]   RdCoefI;
  logic [NRD*CW-1:0]   RdCoefQ;
  logic                CoefReady;
  logic                ShadowFull;
  logic                SwapAck;
  logic                CoefErr;
  logic [AW-1:0]       WrCount;
  logic                DbgState;

  modport master (
    output PushCoef, CoefAddr, CoefI, CoefQ, SwapReq, RdAddr,
    input  RdCoefI, RdCoefQ, CoefReady, ShadowFull, SwapAck, CoefErr,
           WrCount, DbgState
  );

  modport slave (
    input  PushCoef, CoefAddr, CoefI, CoefQ, SwapReq, RdAddr,
    output RdCoefI, RdCoefQ, CoefReady, ShadowFull, SwapAck, CoefErr,
           WrCount, DbgState
  );
endinterface

// File: rtl/firc_coef_bank.sv
// Ping-pong coefficient store for the 29-tap complex FIR.
// The host fills the shadow bank while the multipliers read the active bank.
// A swap is only taken when the shadow bank is complete (ARMED) and the
// sequencer pulses SwapReq at a sample boundary, so taps never change
// mid-sample. DbgState exposes the FILL/ARMED state (0 = FILL, 1 = ARMED).
module firc_coef_bank #(
  parameter int NTAP = 29,
  parameter int AW   = 5,
  parameter int CW   = 27,
  parameter int NRD  = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  firc_coef_bank_if.slave    bus
);

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  localparam logic [AW-1:0] NTAP_A = AW'(NTAP);

  state_t              r_state;
  logic                r_sel;          // index of the active bank
  logic [NTAP-1:0]     r_valid;        // shadow entries written since last swap
  logic [AW-1:0]       r_wr_count;
  logic                r_coef_ready;
  logic                r_shadow_full;
  logic                r_swap_ack;
  logic                r_coef_err;
  logic [NRD*CW-1:0]   r_rd_i;
  logic [NRD*CW-1:0]   r_rd_q;

  // Two banks; contents are deliberately not reset.
  logic [CW-1:0]       r_mem_i [2][NTAP];
  logic [CW-1:0]       r_mem_q [2][NTAP];

  logic                w_addr_ok;
  logic                w_wr_ok;
  logic                w_new_entry;
  logic                w_swap;
  logic [AW-1:0]       w_count_next;

  assign w_addr_ok    = (bus.CoefAddr < NTAP_A);
  assign w_wr_ok      = bus.PushCoef & w_addr_ok;
  // Out-of-range addresses never reach the valid-bit lookup result.
  assign w_new_entry  = w_wr_ok & ~r_valid[bus.CoefAddr];
  assign w_swap       = bus.SwapReq & (r_state == ST_ARMED);
  assign w_count_next = r_wr_count + (w_new_entry ? AW'(1) : AW'(0));

  // Control FSM: tracks shadow fill level and performs the bank swap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= ST_FILL;
      r_sel         <= 1'b0;
      r_valid       <= '0;
      r_wr_count    <= '0;
      r_coef_ready  <= 1'b0;
      r_shadow_full <= 1'b0;
      r_swap_ack    <= 1'b0;
      r_coef_err    <= 1'b0;
    end else begin
      r_coef_err <= bus.PushCoef & ~w_addr_ok;
      r_swap_ack <= w_swap;
      if (w_swap) begin
        // A write in this cycle lands in the bank being activated, but
        // the new shadow starts empty regardless.
        r_sel         <= ~r_sel;
        r_valid       <= '0;
        r_wr_count    <= '0;
        r_coef_ready  <= 1'b1;
        r_shadow_full <= 1'b0;
        r_state       <= ST_FILL;
      end else begin
        if (w_new_entry) begin
          r_valid[bus.CoefAddr] <= 1'b1;
        end
        r_wr_count    <= w_count_next;
        r_shadow_full <= (w_count_next == NTAP_A);
        if (w_count_next == NTAP_A) begin
          r_state <= ST_ARMED;
        end
      end
    end
  end

  // Shadow bank write port; the shadow is always the non-active bank.
  always_ff @(posedge Clk) begin
    if (!Reset && w_wr_ok) begin
      r_mem_i[~r_sel][bus.CoefAddr] <= bus.CoefI;
      r_mem_q[~r_sel][bus.CoefAddr] <= bus.CoefQ;
    end
  end

  // Registered read ports from the active bank; zero when no complete set
  // has ever been activated or the address is out of range.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rd_i <= '0;
      r_rd_q <= '0;
    end else begin
      for (int k = 0; k < NRD; k++) begin
        if (r_coef_ready && (bus.RdAddr[k*AW +: AW] < NTAP_A)) begin
          r_rd_i[k*CW +: CW] <= r_mem_i[r_sel][bus.RdAddr[k*AW +: AW]];
          r_rd_q[k*CW +: CW] <= r_mem_q[r_sel][bus.RdAddr[k*AW +: AW]];
        end else begin
          r_rd_i[k*CW +: CW] <= '0;
          r_rd_q[k*CW +: CW] <= '0;
        end
      end
    end
  end

  assign bus.RdCoefI    = r_rd_i;
  assign bus.RdCoefQ    = r_rd_q;
  assign bus.CoefReady  = r_coef_ready;
  assign bus.ShadowFull = r_shadow_full;
  assign bus.SwapAck    = r_swap_ack;
  assign bus.CoefErr    = r_coef_err;
  assign bus.WrCount    = r_wr_count;
  assign bus.DbgState   = r_state;

endmodule
